// File: rtl/vga_tile_ctrl.sv
// VGA timing generator with a tile-memory pixel source and a colour-bar test pattern.
// Address is issued from the counters; sideband travels alongside so outputs line up with read data.
module vga_tile_ctrl #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned H_FP            = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BP            = 48,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned V_FP            = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BP            = 33,
  parameter int unsigned VGA_BITS        = 8,
  parameter int unsigned TILE_SHIFT      = 5,
  parameter int unsigned COLS            = 20,
  parameter int unsigned BASE_ADDR       = 212,
  parameter int unsigned ADDR_W          = 9,
  parameter int unsigned MEM_LAT         = 1,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [2:0]          invert,
  input  logic                test_mode,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_rdata,
  output logic [VGA_BITS-1:0] vga_r,
  output logic [VGA_BITS-1:0] vga_g,
  output logic [VGA_BITS-1:0] vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_de,
  output logic                frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int          DEPTH   = int'(MEM_LAT) + 1;
  localparam int unsigned BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic       tm;
    logic [2:0] inv;
    logic [2:0] bar;
  } side_t;

  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       h_ext, v_ext;
  side_t             side_in;
  side_t             pipe_q [DEPTH];
  side_t             pipe_d [DEPTH];
  side_t             side_out;
  logic [1:0]        r2, g2, b2;
  logic              unused_rdata_hi;

  function automatic logic [VGA_BITS-1:0] expand(input logic [1:0] c);
    logic [VGA_BITS-1:0] e;
    e = '0;
    for (int i = 0; i < int'(VGA_BITS); i++) begin
      e[VGA_BITS-1-i] = c[(i % 2 == 0) ? 1 : 0];
    end
    return e;
  endfunction

  assign h_ext = 32'(h_cnt_q);
  assign v_ext = 32'(v_cnt_q);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == HW'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
    end else begin
      h_cnt_d = h_cnt_q + 1'b1;
    end
  end

  // Stage 0: address and raw sideband; disabled scan loads idle values everywhere.
  always_comb begin
    side_in    = '0;
    mem_addr_d = ADDR_W'(BASE_ADDR);
    if (en) begin
      mem_addr_d  = ADDR_W'(BASE_ADDR + (h_ext >> TILE_SHIFT) + (v_ext >> TILE_SHIFT) * COLS);
      side_in.hs  = (h_ext >= H_ACTIVE + H_FP) && (h_ext < H_ACTIVE + H_FP + H_SYNC);
      side_in.vs  = (v_ext >= V_ACTIVE + V_FP) && (v_ext < V_ACTIVE + V_FP + V_SYNC);
      side_in.de  = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
      side_in.fs  = (h_ext == 0) && (v_ext == 0);
      side_in.tm  = test_mode;
      side_in.inv = invert;
      side_in.bar = 3'(h_ext / BAR_W);
    end
  end

  always_comb begin
    pipe_d[0] = side_in;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = en ? pipe_q[i-1] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      mem_addr_q <= ADDR_W'(BASE_ADDR);
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      mem_addr_q <= mem_addr_d;
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign mem_addr        = mem_addr_q;
  assign side_out        = pipe_q[DEPTH-1];
  assign unused_rdata_hi = ^mem_rdata[7:6];

  // Last sideband stage meets read data for the same pixel, so the colour path is combinational.
  always_comb begin
    r2 = side_out.tm ? {2{side_out.bar[2]}} : mem_rdata[5:4];
    g2 = side_out.tm ? {2{side_out.bar[1]}} : mem_rdata[3:2];
    b2 = side_out.tm ? {2{side_out.bar[0]}} : mem_rdata[1:0];
    vga_r = '0;
    vga_g = '0;
    vga_b = '0;
    if (side_out.de) begin
      vga_r = expand(r2) ^ {VGA_BITS{side_out.inv[2]}};
      vga_g = expand(g2) ^ {VGA_BITS{side_out.inv[1]}};
      vga_b = expand(b2) ^ {VGA_BITS{side_out.inv[0]}};
    end
    vga_hs      = SYNC_ACTIVE_LOW ? ~side_out.hs : side_out.hs;
    vga_vs      = SYNC_ACTIVE_LOW ? ~side_out.vs : side_out.vs;
    vga_de      = side_out.de;
    frame_start = side_out.fs & side_out.de;
  end

endmodule
